// File: rtl/neg_abs_pipe_pkg.sv
// Shared types for the negate/abs pipeline: operation mode and prefix-core speed selector.
package lau_pkg;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    NEG  = 2'd1,
    ABS  = 2'd2,
    NABS = 2'd3
  } negmode_e;

  typedef enum logic {
    SLOW = 1'b0,
    FAST = 1'b1
  } speed_e;

endpackage

// File: rtl/neg_abs_pipe_prefix.sv
// PrefixAnd: po[i] = &pi[i:0]; log-depth Kogge-Stone network for FAST, ripple chain for SLOW.
module PrefixAnd
  import lau_pkg::*;
#(
  parameter int unsigned width = 9,
  parameter speed_e      speed = FAST
) (
  input  logic [width-1:0] pi,
  output logic [width-1:0] po
);

  if (speed == FAST) begin : g_fast
    always_comb begin : ks
      logic [width-1:0] cur;
      logic [width-1:0] nxt;
      cur = pi;
      nxt = '0;
      for (int unsigned d = 1; d < width; d = d * 2) begin
        nxt = cur;
        for (int unsigned i = d; i < width; i++) begin
          nxt[i] = cur[i] & cur[i - d];
        end
        cur = nxt;
      end
      po = cur;
    end
  end else begin : g_slow
    always_comb begin : rip
      logic acc;
      acc = 1'b1;
      po  = '0;
      for (int unsigned i = 0; i < width; i++) begin
        acc   = acc & pi[i];
        po[i] = acc;
      end
    end
  end

endmodule

// File: rtl/neg_abs_pipe_stage.sv
// neg_pipe_stage: one valid/ready register slice; ready looks through to the downstream slice.
module neg_pipe_stage #(
  parameter int unsigned dw = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [dw-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [dw-1:0] out_data
);

  assign in_ready = !out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/neg_abs_pipe.sv
// neg_abs_pipe: handshaked PASS/NEG/ABS/NABS 2's complementer with overflow flag.
// Define NEG_ABS_SAT_EN to saturate overflowing results to max positive instead of wrapping.
module neg_abs_pipe
  import lau_pkg::*;
#(
  parameter int unsigned width  = 8,
  parameter speed_e      speed  = FAST,
  parameter int unsigned stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] a_i,
  input  negmode_e         mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [width-1:0] z_o,
  output logic             ovf_o
);

  localparam logic [width-1:0] min_neg = {1'b1, {(width-1){1'b0}}};

  logic             neg;
  logic [width:0]   ai;
  logic [width:0]   po;
  logic [width-1:0] sum;
  logic [width-1:0] res;
  logic             ovf;
  logic             unused_po_msb;

  always_comb begin
    neg = 1'b0;
    case (mode_i)
      PASS:    neg = 1'b0;
      NEG:     neg = 1'b1;
      ABS:     neg = a_i[width-1];
      NABS:    neg = ~a_i[width-1];
      default: neg = 1'b0;
    endcase
  end

  // Bit i of ~a+1 flips exactly when every lower inverted bit (and the +1) is 1.
  assign ai = {a_i ^ {width{neg}}, neg};

  PrefixAnd #(
    .width (width + 1),
    .speed (speed)
  ) u_prefix (
    .pi (ai),
    .po (po)
  );

  assign sum           = ai[width:1] ^ po[width-1:0];
  assign unused_po_msb = po[width];
  assign ovf           = neg & (a_i == min_neg);

`ifdef NEG_ABS_SAT_EN
  assign res = ovf ? ~min_neg : sum;
`else
  assign res = sum;
`endif

  for (genvar k = 0; k < stages; k++) begin : g_stage
    logic           in_v;
    logic           in_rdy;
    logic [width:0] in_d;
    logic           out_v;
    logic           out_rdy;
    logic [width:0] out_d;

    if (k == 0) begin : g_head
      assign in_v = in_valid_i;
      assign in_d = {res, ovf};
    end else begin : g_link
      assign in_v = g_stage[k-1].out_v;
      assign in_d = g_stage[k-1].out_d;
    end

    if (k == stages - 1) begin : g_tail
      assign out_rdy = out_ready_i;
    end else begin : g_next
      assign out_rdy = g_stage[k+1].in_rdy;
    end

    neg_pipe_stage #(
      .dw (width + 1)
    ) u_stage (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .in_valid  (in_v),
      .in_ready  (in_rdy),
      .in_data   (in_d),
      .out_valid (out_v),
      .out_ready (out_rdy),
      .out_data  (out_d)
    );
  end

  assign in_ready_o  = g_stage[0].in_rdy;
  assign out_valid_o = g_stage[stages-1].out_v;
  assign z_o         = g_stage[stages-1].out_d[width:1];
  assign ovf_o       = g_stage[stages-1].out_d[0];

endmodule

// File: tb/tb_neg_abs_pipe.sv
// Scoreboard bench for neg_abs_pipe (width=8, stages=2) with an integer-arithmetic reference model.
module tb_neg_abs_pipe;
  import lau_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  negmode_e   mode = PASS;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] z;
  logic       ovf;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  logic       held = 1'b0;
  logic [8:0] held_v = '0;

  always #5 clk = ~clk;

  neg_abs_pipe #(
    .width  (8),
    .speed  (FAST),
    .stages (2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .mode_i      (mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .z_o         (z),
    .ovf_o       (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: signed integer result, overflow when it exceeds the 8-bit positive range.
  function automatic logic [8:0] model(input logic [7:0] av, input negmode_e m);
    int v, r;
    logic o;
    logic [7:0] zz;
    v = int'($signed(av));
    case (m)
      PASS:    r = v;
      NEG:     r = -v;
      ABS:     r = (v < 0) ? -v : v;
      default: r = (v > 0) ? -v : v;
    endcase
    o = (r > 127);
`ifdef NEG_ABS_SAT_EN
    zz = o ? 8'd127 : r[7:0];
`else
    zz = r[7:0];
`endif
    return {zz, o};
  endfunction

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(a, mode));
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {23'd0, z, ovf}, {23'd0, held_v});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got z=%0h ovf=%0b expected no output", z, ovf);
        end else begin
          chk("result", {23'd0, z, ovf}, {23'd0, exp_q.pop_front()});
        end
      end
      held   = out_valid & !out_ready;
      held_v = {z, ovf};
    end
  end

  task automatic send_lat(input logic [7:0] av, input negmode_e m);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; a = av; mode = m;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (in_ready) break;
      lat++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk("latency", lat, 2);
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] da[14];
    negmode_e   dm[14];
    int idx, run, n;
    logic acc;

    // Reset with random input activity
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      a = 8'($urandom); mode = negmode_e'($urandom_range(0, 3));
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_z", {24'd0, z}, 0);
      chk("rst_ovf", {31'd0, ovf}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;

    // Directed modes and overflow corner
    da = '{8'h05, 8'h05, 8'h05, 8'h05, 8'hFB, 8'hFB, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h7F, 8'h00, 8'h01};
    dm = '{PASS, NEG, ABS, NABS, ABS, NABS, PASS, NEG, ABS, NABS, NABS, NEG, NEG, NABS};
    for (int i = 0; i < 14; i++) send_lat(da[i], dm[i]);
    drain();

    // Backpressure: 0x01..0x10 back-to-back with random out_ready
    idx = 1;
    acc = 1'b0;
    while (idx <= 16 || (in_valid && !acc)) begin
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        if (idx <= 16) begin
          in_valid = 1'b1; a = 8'(idx); mode = negmode_e'($urandom_range(0, 3));
          idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = 1'($urandom);
      @(negedge clk);
      acc = in_valid & in_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Full throughput: 100 back-to-back inputs must emerge in 100 consecutive cycles
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          @(posedge clk); #1;
          in_valid = 1'b1; a = 8'($urandom); mode = negmode_e'($urandom_range(0, 3));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        run = 0;
        while (out_valid && run < 200) begin
          run++;
          @(negedge clk);
        end
        chk("throughput_run", run, 100);
      end
    join
    drain();

    // Reset with two transactions in flight
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'h11; mode = NEG;
    @(posedge clk); #1;
    a = 8'h22; mode = ABS;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, out_valid}, 0);
    end
    send_lat(8'h33, NABS);
    drain();

    // Random traffic with random stalls
    acc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = 8'($urandom); mode = negmode_e'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = in_valid & in_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
